// File: rtl/spi_i2c_reg_bank_pkg.sv
// Shared constants for the SPI/I2C register bank: register map, pin map and defaults.
package spi_i2c_reg_bank_pkg;

    localparam int NUM_REGS            = 8;
    localparam int ADDR_W              = 3;
    localparam int SYNC_STAGES_DEFAULT = 2;

    localparam logic [6:0]        I2C_ADDR_DEFAULT = 7'h70;
    localparam logic [ADDR_W-1:0] REG_OUT          = 3'd0;
    localparam logic [ADDR_W-1:0] REG_UIO          = 3'd1;
    localparam logic [ADDR_W-1:0] REG_STATUS       = 3'd7;

    localparam logic [4:0] SPI_FRAME_BITS = 5'd16;

    // ui_in / uio pin positions
    localparam int PIN_CS_N = 0;
    localparam int PIN_SCLK = 1;
    localparam int PIN_MOSI = 2;
    localparam int PIN_MISO = 0;
    localparam int PIN_SDA  = 1;
    localparam int PIN_SCL  = 2;

    function automatic logic [7:0] status_value(input logic [4:0] gp);
        return {gp, 3'b000};
    endfunction

endpackage

// File: rtl/spi_i2c_reg_bank_i2c_target.sv
// I2C target: START/STOP detection, address match, pointer/data writes and register reads.
module spi_i2c_reg_bank_i2c_target
    import spi_i2c_reg_bank_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = I2C_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_i,
    input  logic              sda_i,
    input  logic [7:0]        rd_data_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [7:0]        wdata_o,
    output logic              sda_oe_o
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WDATA    = 3'd3;
    localparam logic [2:0] ST_WACK     = 3'd4;
    localparam logic [2:0] ST_RDATA    = 3'd5;
    localparam logic [2:0] ST_RACK     = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              rw_q, rw_d;
    logic              first_q, first_d;
    logic              mack_q, mack_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              sda_oe_q, sda_oe_d;
    logic              scl_q, sda_q;

    logic start_evt, stop_evt, rise_evt, fall_evt, rx_bit, rx_done;

    assign start_evt = scl_i & scl_q & sda_q & ~sda_i;
    assign stop_evt  = scl_i & scl_q & ~sda_q & sda_i;
    assign rise_evt  = scl_i & ~scl_q;
    assign fall_evt  = ~scl_i & scl_q;
    assign rx_bit    = rise_evt && (cnt_q != 4'd8);
    assign rx_done   = fall_evt && (cnt_q == 4'd8);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        rw_d     = rw_q;
        first_d  = first_q;
        mack_d   = mack_q;
        ptr_d    = ptr_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        sda_oe_d = sda_oe_q;
        if (start_evt) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (stop_evt) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_WDATA: begin
                    if (rx_bit) begin
                        shift_d = {shift_q[6:0], sda_i};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (rx_done) begin
                        cnt_d = '0;
                        if (state_q == ST_ADDR) begin
                            if (shift_q[7:1] == I2C_ADDR) begin
                                sda_oe_d = 1'b1;
                                rw_d     = shift_q[0];
                                state_d  = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            sda_oe_d = 1'b1;
                            state_d  = ST_WACK;
                            if (first_q) begin
                                ptr_d   = shift_q[ADDR_W-1:0];
                                first_d = 1'b0;
                            end else begin
                                we_d    = 1'b1;
                                waddr_d = ptr_q;
                                ptr_d   = ptr_q + 3'd1;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: if (fall_evt) begin
                    if (rw_q) begin
                        shift_d  = rd_data_i;
                        sda_oe_d = ~rd_data_i[7];
                        state_d  = ST_RDATA;
                    end else begin
                        sda_oe_d = 1'b0;
                        first_d  = 1'b1;
                        state_d  = ST_WDATA;
                    end
                end
                ST_WACK: if (fall_evt) begin
                    sda_oe_d = 1'b0;
                    state_d  = ST_WDATA;
                end
                ST_RDATA: begin
                    if (rise_evt) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (rx_done) begin
                        cnt_d    = '0;
                        sda_oe_d = 1'b0;
                        ptr_d    = ptr_q + 3'd1;
                        state_d  = ST_RACK;
                    end else if (fall_evt) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                ST_RACK: begin
                    if (rise_evt) begin
                        mack_d = ~sda_i;
                    end else if (fall_evt) begin
                        if (mack_q) begin
                            shift_d  = rd_data_i;
                            sda_oe_d = ~rd_data_i[7];
                            state_d  = ST_RDATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            rw_q     <= 1'b0;
            first_q  <= 1'b0;
            mack_q   <= 1'b0;
            ptr_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            sda_oe_q <= 1'b0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            rw_q     <= rw_d;
            first_q  <= first_d;
            mack_q   <= mack_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            sda_oe_q <= sda_oe_d;
            scl_q    <= scl_i;
            sda_q    <= sda_i;
        end
    end

    // The received byte stays in shift_q until the next SCL rise, long after the write pulse.
    assign ptr_o    = ptr_q;
    assign we_o     = we_q;
    assign waddr_o  = waddr_q;
    assign wdata_o  = shift_q;
    assign sda_oe_o = sda_oe_q;

endmodule

// File: rtl/spi_i2c_reg_bank.sv
// 8x8 register bank shared by an SPI mode-0 target and an I2C target; reg0/reg1 drive pins.
module spi_i2c_reg_bank
    import spi_i2c_reg_bank_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = I2C_ADDR_DEFAULT,
    parameter int         SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Idle levels, LSB first: cs_n=1, sclk=0, mosi=0, scl=1, sda=1.
    localparam logic [4:0] SYNC_IDLE = 5'b11001;

    logic [4:0] raw_pins;
    logic [4:0] sync_q [SYNC_STAGES];
    logic       cs_n_s, sclk_s, mosi_s, scl_s, sda_s;
    logic       sclk_prev_q, sclk_rise, sclk_fall;
    logic       unused_inputs;

    logic [7:0]        regs_q [NUM_REGS];
    logic [4:0]        bit_cnt_q;
    logic [6:0]        shift_q;
    logic              cmd_rw_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [7:0]        rd_shift_q;
    logic              miso_q;

    logic [ADDR_W-1:0] spi_rd_addr, i2c_ptr, i2c_waddr;
    logic [7:0]        spi_rd_data, i2c_rd_data, spi_wdata, i2c_wdata;
    logic              spi_we, i2c_we, i2c_sda_oe;

    assign raw_pins = {uio_in[PIN_SDA], uio_in[PIN_SCL], ui_in[PIN_MOSI],
                       ui_in[PIN_SCLK], ui_in[PIN_CS_N]};
    assign unused_inputs = &{1'b0, ena, uio_in[7:3], uio_in[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
            sclk_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking, so each stage takes its predecessor's value from before this edge.
            sync_q[0] <= raw_pins;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_prev_q <= sclk_s;
        end
    end

    assign {sda_s, scl_s, mosi_s, sclk_s, cs_n_s} = sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    assign spi_rd_addr = {shift_q[1:0], mosi_s};
    assign spi_rd_data = (spi_rd_addr == REG_STATUS) ? status_value(ui_in[7:3]) : regs_q[spi_rd_addr];
    assign i2c_rd_data = (i2c_ptr == REG_STATUS) ? status_value(ui_in[7:3]) : regs_q[i2c_ptr];

    assign spi_we    = ~cs_n_s & sclk_rise & cmd_rw_q & (bit_cnt_q == SPI_FRAME_BITS - 5'd1);
    assign spi_wdata = {shift_q, mosi_s};

    // Counter holds at zero while deselected, so a short frame never reaches the write point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            cmd_rw_q   <= 1'b0;
            cmd_addr_q <= '0;
            rd_shift_q <= '0;
            miso_q     <= 1'b0;
        end else if (cs_n_s) begin
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
        end else if (sclk_rise && bit_cnt_q != SPI_FRAME_BITS) begin
            shift_q   <= {shift_q[5:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
                cmd_rw_q   <= shift_q[6];
                cmd_addr_q <= spi_rd_addr;
                rd_shift_q <= spi_rd_data;
            end
        end else if (sclk_fall && bit_cnt_q >= 5'd8 && !cmd_rw_q) begin
            miso_q     <= rd_shift_q[7];
            rd_shift_q <= {rd_shift_q[6:0], 1'b0};
        end
    end

    spi_i2c_reg_bank_i2c_target #(
        .I2C_ADDR (I2C_ADDR)
    ) u_i2c (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_s),
        .sda_i     (sda_s),
        .rd_data_i (i2c_rd_data),
        .ptr_o     (i2c_ptr),
        .we_o      (i2c_we),
        .waddr_o   (i2c_waddr),
        .wdata_o   (i2c_wdata),
        .sda_oe_o  (i2c_sda_oe)
    );

    // SPI has priority when both interfaces hit the same register in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the bank is plain flops and must power up as 0x00, so every entry is reset.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            if (spi_we && cmd_addr_q != REG_STATUS)
                regs_q[cmd_addr_q] <= spi_wdata;
            if (i2c_we && i2c_waddr != REG_STATUS && !(spi_we && cmd_addr_q == i2c_waddr))
                regs_q[i2c_waddr] <= i2c_wdata;
        end
    end

    assign uo_out = regs_q[REG_OUT];

    assign uio_out[7:3]    = regs_q[REG_UIO][7:3];
    assign uio_out[PIN_SCL] = 1'b0;
    assign uio_out[PIN_SDA] = 1'b0;
    assign uio_out[PIN_MISO] = miso_q;

    assign uio_oe[7:3]     = 5'b11111;
    assign uio_oe[PIN_SCL]  = 1'b0;
    assign uio_oe[PIN_SDA]  = i2c_sda_oe;
    assign uio_oe[PIN_MISO] = 1'b1;

endmodule

// File: tb/tb_spi_i2c_reg_bank.sv
// Directed bench for spi_i2c_reg_bank: SPI vector table plus I2C and corner-case sequences.
module tb_spi_i2c_reg_bank;

    localparam int SPI_HALF = 8;
    localparam int I2C_HALF = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
    logic       spi_cs_n = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
    logic [4:0] gp_in = 5'b00000;
    logic       m_scl = 1'b1, m_sda = 1'b1;
    logic       sda_bus;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        logic [7:0] exp_uo;
    } vec_t;

    vec_t vecs [14];

    assign sda_bus = m_sda & ~(uio_oe[1] & ~uio_out[1]);
    assign ui_in   = {gp_in, spi_mosi, spi_sclk, spi_cs_n};
    assign uio_in  = {5'b00000, m_scl, sda_bus, 1'b0};

    always #5 clk = ~clk;

    spi_i2c_reg_bank dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_xfer(input logic [7:0] cmd, input logic [7:0] data, input int nbits,
                            output logic [7:0] rd);
        rd = 8'h00;
        spi_cs_n = 1'b0;
        wait_clk(SPI_HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 8) ? cmd[7-i] : data[15-i];
            wait_clk(SPI_HALF);
            if (i >= 8) rd[15-i] = uio_out[0];
            spi_sclk = 1'b1;
            wait_clk(SPI_HALF);
            spi_sclk = 1'b0;
        end
        wait_clk(SPI_HALF);
        spi_cs_n = 1'b1;
        wait_clk(SPI_HALF);
    endtask

    task automatic spi_read(input logic [2:0] addr, output logic [7:0] rd);
        spi_xfer({5'b00000, addr}, 8'h00, 16, rd);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clk(I2C_HALF);
        m_scl = 1'b1; wait_clk(I2C_HALF);
        m_sda = 1'b0; wait_clk(I2C_HALF);
        m_scl = 1'b0; wait_clk(I2C_HALF);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(I2C_HALF);
        m_scl = 1'b1; wait_clk(I2C_HALF);
        m_sda = 1'b1; wait_clk(I2C_HALF);
    endtask

    task automatic i2c_bit(input logic b, output logic s);
        m_sda = b;
        wait_clk(I2C_HALF);
        m_scl = 1'b1;
        wait_clk(I2C_HALF / 2);
        s = sda_bus;
        wait_clk(I2C_HALF / 2);
        m_scl = 1'b0;
        wait_clk(2);
    endtask

    task automatic i2c_wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
        i2c_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic i2c_rbyte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            d[i] = s;
        end
        i2c_bit(~ack, s);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rd;
        logic        ack, s;
        logic [15:0] frame;
        logic [7:0]  d22;

        for (int a = 0; a < 7; a++) vecs[a] = '{1'b0, 3'(a), 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 3'd0, 8'h5A, 8'h00, 8'h5A};
        vecs[8]  = '{1'b0, 3'd0, 8'h00, 8'h5A, 8'h5A};
        vecs[9]  = '{1'b1, 3'd5, 8'hC3, 8'h00, 8'h5A};
        vecs[10] = '{1'b0, 3'd5, 8'h00, 8'hC3, 8'h5A};
        vecs[11] = '{1'b0, 3'd7, 8'h00, 8'hA8, 8'h5A};
        vecs[12] = '{1'b1, 3'd7, 8'hFF, 8'h00, 8'h5A};
        vecs[13] = '{1'b0, 3'd7, 8'h00, 8'hA8, 8'h5A};

        wait_clk(3);
        check("reset uo_out", uo_out, 8'h00);
        check("reset uio_oe", uio_oe, 8'hF9);
        check("reset uio_out", uio_out, 8'h00);
        rst_n = 1'b1;
        wait_clk(3);
        gp_in = 5'b10101;

        for (int v = 0; v < 14; v++) begin
            spi_xfer({vecs[v].wr, 4'b0000, vecs[v].addr}, vecs[v].data, 16, rd);
            if (!vecs[v].wr) check($sformatf("spi vec %0d read", v), rd, vecs[v].exp_rd);
            check($sformatf("spi vec %0d uo_out", v), uo_out, vecs[v].exp_uo);
            check($sformatf("spi vec %0d miso idle", v), {7'd0, uio_out[0]}, 8'h00);
        end

        i2c_start();
        i2c_wbyte(8'hE0, ack); check("i2c wr addr ack", {7'd0, ack}, 8'h01);
        i2c_wbyte(8'h01, ack); check("i2c wr ptr ack", {7'd0, ack}, 8'h01);
        i2c_wbyte(8'hF0, ack); check("i2c wr data0 ack", {7'd0, ack}, 8'h01);
        i2c_wbyte(8'h33, ack); check("i2c wr data1 ack", {7'd0, ack}, 8'h01);
        i2c_stop();
        wait_clk(4);
        check("uio_out upper", {3'd0, uio_out[7:3]}, 8'h1E);
        check("i2c sda released", {7'd0, uio_oe[1]}, 8'h00);
        spi_read(3'd1, rd); check("reg1 via spi", rd, 8'hF0);
        spi_read(3'd2, rd); check("reg2 via spi", rd, 8'h33);

        i2c_start();
        i2c_wbyte(8'hE0, ack); check("i2c rd addr ack", {7'd0, ack}, 8'h01);
        i2c_wbyte(8'h01, ack); check("i2c rd ptr ack", {7'd0, ack}, 8'h01);
        i2c_start();
        i2c_wbyte(8'hE1, ack); check("i2c rd raddr ack", {7'd0, ack}, 8'h01);
        i2c_rbyte(1'b1, rd);   check("i2c rd byte0", rd, 8'hF0);
        i2c_rbyte(1'b0, rd);   check("i2c rd byte1", rd, 8'h33);
        check("i2c released after nack", {7'd0, uio_oe[1]}, 8'h00);
        i2c_stop();

        i2c_start();
        i2c_wbyte(8'hE2, ack); check("i2c addr 0x71 no ack", {7'd0, ack}, 8'h00);
        check("i2c 0x71 sda released", {7'd0, uio_oe[1]}, 8'h00);
        i2c_stop();

        spi_xfer(8'h84, 8'h77, 12, rd);
        spi_read(3'd4, rd); check("spi abort reg4", rd, 8'h00);

        // SPI 16th rise lands one clock after the I2C 8th fall so both writes hit the same cycle.
        frame = 16'h8311;
        d22   = 8'h22;
        i2c_start();
        i2c_wbyte(8'hE0, ack);
        i2c_wbyte(8'h03, ack);
        spi_cs_n = 1'b0;
        wait_clk(SPI_HALF);
        for (int i = 0; i < 15; i++) begin
            spi_mosi = frame[15-i];
            wait_clk(SPI_HALF);
            spi_sclk = 1'b1;
            wait_clk(SPI_HALF);
            spi_sclk = 1'b0;
        end
        spi_mosi = frame[0];
        for (int i = 7; i >= 1; i--) i2c_bit(d22[i], s);
        m_sda = d22[0];
        wait_clk(I2C_HALF);
        m_scl = 1'b1;
        wait_clk(I2C_HALF);
        @(negedge clk) m_scl = 1'b0;
        @(negedge clk) spi_sclk = 1'b1;
        wait_clk(SPI_HALF);
        spi_sclk = 1'b0;
        wait_clk(SPI_HALF);
        spi_cs_n = 1'b1;
        wait_clk(2);
        i2c_bit(1'b1, s);
        check("collision i2c ack", {7'd0, ~s}, 8'h01);
        i2c_stop();
        spi_read(3'd3, rd); check("collision reg3 spi wins", rd, 8'h11);

        i2c_start();
        for (int i = 7; i >= 0; i--) i2c_bit(frame[i] ^ frame[i] ? 1'b0 : (i >= 5), s);
        wait_clk(4);
        check("ack drive before reset", {7'd0, uio_oe[1]}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("reset mid-xfer uio_oe", uio_oe, 8'hF9);
        check("reset mid-xfer uo_out", uo_out, 8'h00);
        wait_clk(2);
        rst_n = 1'b1;
        m_scl = 1'b1;
        wait_clk(I2C_HALF);
        m_sda = 1'b1;
        wait_clk(I2C_HALF);
        spi_read(3'd1, rd); check("reg1 after reset", rd, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
